horner_poly_engine: RTL and testbench



---
 rtl/horner_pkg.sv | 36 +++
 rtl/horner_poly_engine_mac.sv | 32 +++
 rtl/horner_poly_engine.sv | 108 ++++++++++
 tb/tb_horner_poly_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/horner_pkg.sv
// Shared definitions for the Horner polynomial engine: FSM encoding, the wide
// intermediate type used by the MAC, rounding constant and saturation helper.
package horner_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ITER = ST_ITER,
      OUT  = ST_OUT
   } state_e;

   // Holds a full 2*WIDTH product plus rounding and coefficient carries for WIDTH <= 64.
   localparam int SAT_IW = 130;
   typedef logic signed [SAT_IW-1:0] wide_t;

   function automatic wide_t round_const(input int frac);
      return wide_t'(1) <<< (frac - 1);
   endfunction

   function automatic wide_t sat_to_width(input wide_t s, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (w - 1));
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/horner_poly_engine_mac.sv
// Combinational fixed-point multiply, round-half-up, add and saturate:
// result = sat((acc*x + 2^(FRAC-1)) >>> FRAC + c).
module horner_mac
   import horner_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic signed [WIDTH-1:0] acc,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] c,
   output logic signed [WIDTH-1:0] result,
   output logic                    sat
);

   localparam int PW = 2 * WIDTH;

   logic signed [PW-1:0] p;
   wide_t p_r;
   wide_t s;
   wide_t clamped;

   always_comb begin
      p       = PW'(acc) * PW'(x);
      p_r     = (wide_t'(p) + round_const(FRAC)) >>> FRAC;
      s       = p_r + wide_t'(c);
      clamped = sat_to_width(s, WIDTH);
      sat     = (clamped != s);
      result  = clamped[WIDTH-1:0];
   end

endmodule

// File: rtl/horner_poly_engine.sv
// Fixed-point Horner polynomial evaluator with a writable coefficient bank,
// valid/ready operand and result handshakes, saturation and overflow flag.
module horner_poly_engine
   import horner_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int FRAC    = 16,
   parameter  int MAX_DEG = 7,
   localparam int DW      = $clog2(MAX_DEG + 1)
) (
   input  logic             clk_n,
   input  logic             rst_n,
   input  logic             coef_wr_en,
   input  logic [DW-1:0]    coef_wr_addr,
   input  logic [WIDTH-1:0] coef_wr_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [DW-1:0]    in_deg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_ovf
);

   // Handshakes: a transfer happens on a falling clk_n edge where valid and
   // ready are both high; valid and its payload hold until that edge.

   localparam logic [DW:0] MAX_DEG_W = (DW + 1)'(MAX_DEG);

   state_e                  state;
   logic signed [WIDTH-1:0] coef [MAX_DEG+1];
   logic signed [WIDTH-1:0] x_q;
   logic signed [WIDTH-1:0] acc;
   logic signed [WIDTH-1:0] mac_c;
   logic signed [WIDTH-1:0] mac_res;
   logic [DW-1:0]           idx;
   logic [DW-1:0]           idx_m1;
   logic [DW-1:0]           deg_eff;
   logic                    ovf;
   logic                    mac_sat;
   logic                    wr_ok;

   assign deg_eff  = ({1'b0, in_deg} > MAX_DEG_W) ? MAX_DEG_W[DW-1:0] : in_deg;
   assign wr_ok    = coef_wr_en && ({1'b0, coef_wr_addr} <= MAX_DEG_W);
   assign idx_m1   = idx - DW'(1);
   assign mac_c    = coef[idx_m1];
   assign in_ready = (state == IDLE);

   horner_mac #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mac (
      .acc    (acc),
      .x      (x_q),
      .c      (mac_c),
      .result (mac_res),
      .sat    (mac_sat)
   );

   always_ff @(negedge clk_n or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         x_q        <= '0;
         acc        <= '0;
         idx        <= '0;
         ovf        <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_ovf    <= 1'b0;
         for (int i = 0; i <= MAX_DEG; i++) coef[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               // The accept below reads the bank before this edge's write lands.
               if (wr_ok) coef[coef_wr_addr] <= coef_wr_data;
               if (in_valid) begin
                  x_q   <= in_x;
                  acc   <= coef[deg_eff];
                  idx   <= deg_eff;
                  ovf   <= 1'b0;
                  state <= ITER;
               end
            end
            ITER: begin
               if (idx == '0) begin
                  out_result <= acc;
                  out_ovf    <= ovf;
                  out_valid  <= 1'b1;
                  state      <= OUT;
               end else begin
                  acc <= mac_res;
                  idx <= idx_m1;
                  ovf <= ovf | mac_sat;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_horner_poly_engine.sv
// Directed and randomized bench for horner_poly_engine in Q8.8 (WIDTH=16,
// FRAC=8): one instance with MAX_DEG=7, one with MAX_DEG=5 for degree clamping.
module tb_horner_poly_engine;

   localparam int W = 16;
   localparam int F = 8;

   logic          clk_n = 1'b1;
   logic          rst_n = 1'b0;
   logic          coef_wr_en = 1'b0;
   logic          coef_wr_en5 = 1'b0;
   logic [2:0]    coef_wr_addr = '0;
   logic [W-1:0]  coef_wr_data = '0;
   logic          in_valid = 1'b0;
   logic          in_valid5 = 1'b0;
   logic [W-1:0]  in_x = '0;
   logic [2:0]    in_deg = '0;
   logic          out_ready = 1'b0;
   logic          out_ready5 = 1'b0;
   logic          in_ready, in_ready5;
   logic          out_valid, out_valid5;
   logic [W-1:0]  out_result, out_result5;
   logic          out_ovf, out_ovf5;

   logic [W:0]    exp_q[$];
   logic [W:0]    exp5_q[$];
   logic [W:0]    last_obs;
   int            m_coef[8];
   int            m5_coef[8];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk_n = ~clk_n;

   horner_poly_engine #(.WIDTH(W), .FRAC(F), .MAX_DEG(7)) dut (
      .clk_n(clk_n), .rst_n(rst_n),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_deg(in_deg),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf)
   );

   horner_poly_engine #(.WIDTH(W), .FRAC(F), .MAX_DEG(5)) dut5 (
      .clk_n(clk_n), .rst_n(rst_n),
      .coef_wr_en(coef_wr_en5), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_x(in_x), .in_deg(in_deg),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_result(out_result5), .out_ovf(out_ovf5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Reference: plain integer Horner with explicit clamping, in Q8.8.
   function automatic logic [W:0] model(input int c[8], input int x, input int d);
      longint acc;
      longint p;
      bit     ov;
      ov  = 1'b0;
      acc = c[d];
      for (int i = d - 1; i >= 0; i--) begin
         p   = (acc * longint'(x) + 128) >>> 8;
         acc = p + c[i];
         if (acc > 32767) begin acc = 32767; ov = 1'b1; end
         else if (acc < -32768) begin acc = -32768; ov = 1'b1; end
      end
      return {ov, acc[15:0]};
   endfunction

   task automatic wr(input int a, input logic [W-1:0] d);
      @(posedge clk_n);
      coef_wr_en = 1'b1; coef_wr_addr = a[2:0]; coef_wr_data = d;
      @(negedge clk_n);
      #1 coef_wr_en = 1'b0;
      m_coef[a] = sx(d);
   endtask

   task automatic wr5(input int a, input logic [W-1:0] d);
      @(posedge clk_n);
      coef_wr_en5 = 1'b1; coef_wr_addr = a[2:0]; coef_wr_data = d;
      @(negedge clk_n);
      #1 coef_wr_en5 = 1'b0;
      if (a <= 5) m5_coef[a] = sx(d);
   endtask

   task automatic eval(input logic [W-1:0] x, input int deg, input int hold,
                       input bit iter_wr, input string tag);
      int n;
      logic [W:0] e;
      @(posedge clk_n);
      in_x = x; in_deg = deg[2:0]; in_valid = 1'b1;
      check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      exp_q.push_back(model(m_coef, sx(x), deg));
      @(negedge clk_n);
      #1 in_valid = 1'b0;
      check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      if (iter_wr) begin
         coef_wr_en = 1'b1; coef_wr_addr = 3'd0; coef_wr_data = 16'h7777;
      end
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk_n);
         #1 coef_wr_en = 1'b0;
         n++;
      end
      check({tag, "_latency"}, n, deg + 1);
      e = exp_q.pop_front();
      last_obs = {out_ovf, out_result};
      check({tag, "_result"}, {16'd0, out_result}, {16'd0, e[W-1:0]});
      check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e[W]});
      for (int k = 0; k < hold; k++) begin
         @(negedge clk_n);
         #1;
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_result"}, {16'd0, out_result}, {16'd0, e[W-1:0]});
         check({tag, "_hold_ovf"}, {31'd0, out_ovf}, {31'd0, e[W]});
         check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk_n);
      out_ready = 1'b1;
      @(negedge clk_n);
      #1 out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic eval5(input logic [W-1:0] x, input int deg, input string tag);
      int n;
      int d;
      logic [W:0] e;
      d = (deg > 5) ? 5 : deg;
      @(posedge clk_n);
      in_x = x; in_deg = deg[2:0]; in_valid5 = 1'b1;
      exp5_q.push_back(model(m5_coef, sx(x), d));
      @(negedge clk_n);
      #1 in_valid5 = 1'b0;
      n = 0;
      while (!out_valid5 && n < 20) begin
         @(negedge clk_n);
         #1 n++;
      end
      check({tag, "_latency"}, n, d + 1);
      e = exp5_q.pop_front();
      last_obs = {out_ovf5, out_result5};
      check({tag, "_result"}, {16'd0, out_result5}, {16'd0, e[W-1:0]});
      check({tag, "_ovf"}, {31'd0, out_ovf5}, {31'd0, e[W]});
      @(posedge clk_n);
      out_ready5 = 1'b1;
      @(negedge clk_n);
      #1 out_ready5 = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid5}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin m_coef[i] = 0; m5_coef[i] = 0; end
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", {16'd0, out_result}, 32'd0);
      check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_in_ready5", {31'd0, in_ready5}, 32'd1);
      @(posedge clk_n);
      rst_n = 1'b1;

      wr(0, 16'h0100); wr(1, 16'h0080); wr(2, 16'h0040);
      eval(16'h0200, 2, 0, 1'b0, "quad");
      check("quad_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h0300});

      wr(0, 16'h0100); wr(1, 16'h0100); wr(2, 16'h0100);
      eval(16'hFF00, 2, 0, 1'b0, "neg_x");
      check("neg_x_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h0100});
      eval(16'hFF00, 0, 0, 1'b0, "deg0");
      check("deg0_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h0100});

      wr(0, 16'h0000); wr(1, 16'h7F00);
      eval(16'h0200, 1, 0, 1'b0, "sat_hi");
      check("sat_hi_lit", {15'd0, last_obs}, {15'd0, 1'b1, 16'h7FFF});
      wr(1, 16'h8100);
      eval(16'h0200, 1, 0, 1'b0, "sat_lo");
      check("sat_lo_lit", {15'd0, last_obs}, {15'd0, 1'b1, 16'h8000});
      eval(16'h0100, 2, 0, 1'b0, "no_sat");
      check("no_sat_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h8200});

      eval(16'h0100, 2, 5, 1'b0, "backpressure");
      eval(16'h0100, 1, 0, 1'b1, "iter_write");
      eval(16'h0100, 0, 0, 1'b0, "bank_kept");
      check("bank_kept_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h0000});

      for (int i = 0; i < 6; i++) wr5(i, 16'h0100);
      wr5(6, 16'h4000); wr5(7, 16'h4000);
      eval5(16'h0080, 7, "deg_clamp");
      check("deg_clamp_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h01F8});

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 4; i++) wr(i, 16'($urandom_range(0, 65535)));
         eval(16'($urandom_range(0, 65535)), $urandom_range(0, 7), $urandom_range(0, 2), 1'b0, "rand");
      end

      for (int i = 0; i < 8; i++) wr(i, 16'h0100);
      @(posedge clk_n);
      in_x = 16'h0100; in_deg = 3'd7; in_valid = 1'b1;
      @(negedge clk_n);
      #1 in_valid = 1'b0;
      @(negedge clk_n);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_out_result", {16'd0, out_result}, 32'd0);
      check("abort_out_ovf", {31'd0, out_ovf}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk_n);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin m_coef[i] = 0; m5_coef[i] = 0; end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_n);
         #1 check("abort_no_result", {31'd0, out_valid}, 32'd0);
      end
      eval(16'h0300, 7, 0, 1'b0, "bank_cleared");
      check("bank_cleared_lit", {15'd0, last_obs}, {15'd0, 1'b0, 16'h0000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
